pwconv_seq: RTL
===============

Name: pwconv_seq

Overview:
Parametrised pointwise (1x1) convolution engine with int8 rescale for the DSCNN datapath.
- Accepts one tile of PIXELS pixels x IN_CH channels, then streams weights one output channel at a time and emits OUT_CH rescaled int8 vectors.
- Successor to the fixed 36-channel PW stage. Adds generic channel counts, valid/ready handshakes on all three streams, runtime scale/shift, optional ReLU and an output channel index.
- Sits between the DWConv stage and the next layer's line buffer.

Parameters:
DATA_W, 8, activation width (signed)
W_W, 8, weight width (signed)
BIAS_W, 16, bias width (signed)
PIXELS, 36, pixels per tile (parallel MAC lanes)
IN_CH, 32, input channels per pixel (MAC iterations)
OUT_CH, 32, output channels per tile
MULT_W, 16, rescale multiplier width (unsigned)
SHIFT_W, 5, rescale shift width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
tile_valid_i  in  1  tile offered
tile_ready_o  out  1  tile accepted when valid&ready
tile_pixel_i  in  PIXELS*IN_CH*DATA_W  pixel p channel c at bits [(p*IN_CH+c)*DATA_W +: DATA_W]
scale_mult_i  in  MULT_W  rescale multiplier, sampled at tile accept
scale_shift_i  in  SHIFT_W  rescale right shift, sampled at tile accept
relu_en_i  in  1  ReLU enable, sampled at tile accept
w_valid_i  in  1  weight vector offered
w_ready_o  out  1  weight accepted when valid&ready
w_i  in  IN_CH*W_W  weights for the current output channel, channel c at [c*W_W +: W_W]
bias_i  in  BIAS_W  bias, qualified with w_valid_i
out_valid_o  out  1  output vector valid
out_ready_i  in  1  downstream ready
out_pixel_o  out  PIXELS*DATA_W  int8 results, lane p at [p*DATA_W +: DATA_W]
out_ch_o  out  max(1,$clog2(OUT_CH))  output channel index
out_last_o  out  1  high with the final output channel of a tile
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset: FSM=IDLE. All outputs are 0 except tile_ready_o=1. Tile, weight, accumulator and cfg registers are cleared.
- ACC_W = DATA_W+W_W+$clog2(IN_CH)+1. The bias is sign-extended into ACC_W.
- FSM states:
  - IDLE: tile_ready_o=1. On tile_valid_i, latch tile and cfg, set oc=0, go to WAIT_W.
  - WAIT_W: w_ready_o=1. On w_valid_i, latch w_i, set acc[p]=bias for every lane, set ic=0, go to MAC.
  - MAC: each cycle acc[p] += x[p][ic]*w[ic] for all lanes, ic++. After IN_CH cycles go to RSC.
  - RSC: one cycle. Register the rescaled results, go to OUT.
  - OUT: out_valid_o=1, with out_pixel_o, out_ch_o=oc and out_last_o=(oc==OUT_CH-1) held stable. On out_ready_i: if last, go to IDLE; otherwise oc++ and go to WAIT_W.
- Latency: out_valid_o rises IN_CH+1 cycles after the weight-accept edge.
- Per-tile minimum: OUT_CH*(IN_CH+3) cycles, plus 1 for the tile accept.
- Rescale per lane:
  - prod = acc*scale_mult (signed x unsigned, ACC_W+MULT_W+1 bits).
  - If shift>0, add 1<<(shift-1) (round half up), then arithmetic shift right by shift.
  - If relu_en, clamp negatives to 0.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Handshake rules:
  - tile_valid_i is ignored while not IDLE (tile_ready_o=0).
  - w_valid_i is ignored outside WAIT_W.
  - Weight starvation holds WAIT_W indefinitely.
  - Backpressure (out_ready_i=0) holds OUT with all outputs stable.
- Back-to-back tiles: a new tile is accepted no earlier than the cycle after the last output handshake, because IDLE is re-entered first.
- Cfg inputs are used only as captured at tile accept; changes mid-tile have no effect.
- OUT_CH=1: out_last_o=1 on the single output. IN_CH=1: MAC lasts one cycle.
- Reset mid-operation: immediate return to the reset state. Partial results are discarded and no output is emitted.

Decomposition:
- Package pwconv_pkg holds:
  - state enum (IDLE, WAIT_W, MAC, RSC, OUT)
  - acc_w(DATA_W,W_W,IN_CH) function
  - saturation-limit constants
- Sub-module pwconv_rescale_lane (one per lane, generated): combinational multiply, round, shift, ReLU and saturate. Its output is registered in RSC by the parent.

Test Plan:
Bench params: PIXELS=2, IN_CH=4, OUT_CH=2, DATA_W=8, W_W=8, BIAS_W=16, MULT_W=16, SHIFT_W=5.
1. x=1, w=1, bias=0, mult=1, shift=0 -> both lanes 4. out_valid 5 cycles after weight accept. out_ch=0 then 1. out_last only on ch 1.
2. Saturation and ReLU:
   - x=127, w=127 (acc 64516) -> 127.
   - x=-128, w=127 -> -128.
   - Same tile with relu_en=1 -> 0.
3. Rounding, shift=1, mult=1:
   - x=1, w=1, bias=1 (acc 5) -> 3.
   - x=-1, w=1, bias=-1 (acc -5) -> -2.
   - mult=3, shift=2, acc 4 -> 3.
4. Backpressure and starvation:
   - Hold out_ready=0 for 10 cycles -> outputs stable, w_ready=0, tile_ready=0.
   - Delay w_valid 7 cycles -> FSM stays in WAIT_W, result unchanged.
5. Back-to-back tiles, tile_valid held high -> second tile accepted exactly one cycle after the first tile's last output handshake. Cfg changed mid-tile has no effect.
6. Assert rst_n low during MAC -> all outputs 0 and busy_o=0 immediately. tile_ready_o=1 after release. No stray out_valid.

Source files
------------

// File: rtl/pwconv_pkg.sv
// ---------------------------------------------------------------------------
// pwconv_pkg
// Shared types and helpers for the pointwise convolution engine:
//   - state_t  : engine FSM states
//   - acc_w()  : accumulator width for a given activation/weight/channel count
//   - idx_w()  : counter width for an index over n items (at least 1 bit)
//   - sat_hi() / sat_lo() : signed saturation limits for a result width
// ---------------------------------------------------------------------------
package pwconv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_W = 3'd1,
        MAC    = 3'd2,
        RSC    = 3'd3,
        OUT    = 3'd4
    } state_t;

    // One guard bit on top of the full product width plus channel growth.
    function automatic int acc_w(int data_w, int w_w, int in_ch);
        return data_w + w_w + $clog2(in_ch) + 1;
    endfunction

    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic longint sat_hi(int data_w);
        return (longint'(1) <<< (data_w - 1)) - 1;
    endfunction

    function automatic longint sat_lo(int data_w);
        return -(longint'(1) <<< (data_w - 1));
    endfunction

endpackage

// File: rtl/pwconv_seq_if.sv
// ---------------------------------------------------------------------------
// pwconv_seq_if
// Bundles the three streams of the pointwise convolution engine.
//   tile stream   : tile_valid_i / tile_ready_o, tile_pixel_i, cfg inputs
//                   (scale_mult_i, scale_shift_i, relu_en_i)
//   weight stream : w_valid_i / w_ready_o, w_i, bias_i
//   output stream : out_valid_o / out_ready_i, out_pixel_o, out_ch_o,
//                   out_last_o
//   status        : busy_o
// Suffixes are from the engine's point of view. The engine uses the slave
// modport, the producer/consumer side uses master.
// ---------------------------------------------------------------------------
interface pwconv_seq_if
    import pwconv_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int W_W     = 8,
    parameter int BIAS_W  = 16,
    parameter int PIXELS  = 36,
    parameter int IN_CH   = 32,
    parameter int OUT_CH  = 32,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 5
);
    localparam int OC_W = idx_w(OUT_CH);

    logic                             tile_valid_i;
    logic                             tile_ready_o;
    logic [PIXELS*IN_CH*DATA_W-1:0]   tile_pixel_i;
    logic [MULT_W-1:0]                scale_mult_i;
    logic [SHIFT_W-1:0]               scale_shift_i;
    logic                             relu_en_i;

    logic                             w_valid_i;
    logic                             w_ready_o;
    logic [IN_CH*W_W-1:0]             w_i;
    logic [BIAS_W-1:0]                bias_i;

    logic                             out_valid_o;
    logic                             out_ready_i;
    logic [PIXELS*DATA_W-1:0]         out_pixel_o;
    logic [OC_W-1:0]                  out_ch_o;
    logic                             out_last_o;

    logic                             busy_o;

    modport master (
        output tile_valid_i, tile_pixel_i, scale_mult_i, scale_shift_i, relu_en_i,
        output w_valid_i, w_i, bias_i, out_ready_i,
        input  tile_ready_o, w_ready_o, out_valid_o, out_pixel_o, out_ch_o,
        input  out_last_o, busy_o
    );

    modport slave (
        input  tile_valid_i, tile_pixel_i, scale_mult_i, scale_shift_i, relu_en_i,
        input  w_valid_i, w_i, bias_i, out_ready_i,
        output tile_ready_o, w_ready_o, out_valid_o, out_pixel_o, out_ch_o,
        output out_last_o, busy_o
    );

endinterface

// File: rtl/pwconv_rescale_lane.sv
// ---------------------------------------------------------------------------
// pwconv_rescale_lane
// Combinational int8 rescale of one accumulator lane:
//   prod = acc * mult (signed x unsigned), round half up by adding
//   1<<(shift-1) when shift>0, arithmetic shift right, optional ReLU,
//   saturate to the signed DATA_W range.
// Ports:
//   acc_i     signed accumulator
//   mult_i    unsigned multiplier
//   shift_i   right shift amount
//   relu_en_i clamp negatives to zero
//   res_o     saturated DATA_W-bit result
// ---------------------------------------------------------------------------
module pwconv_rescale_lane
    import pwconv_pkg::*;
#(
    parameter int ACC_W   = 19,
    parameter int DATA_W  = 8,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 5
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic [MULT_W-1:0]        mult_i,
    input  logic [SHIFT_W-1:0]       shift_i,
    input  logic                     relu_en_i,
    output logic [DATA_W-1:0]        res_o
);
    localparam int PROD_W = ACC_W + MULT_W + 1;
    // One extra bit so the rounding add can never wrap.
    localparam int SUM_W  = PROD_W + 1;

    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(sat_hi(DATA_W));
    localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(sat_lo(DATA_W));

    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  rnd;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  shifted;

    always_comb begin
        // Zero-extend the multiplier so the product stays a signed multiply.
        prod = PROD_W'(acc_i) * PROD_W'($signed({1'b0, mult_i}));

        rnd = '0;
        if (shift_i != '0) begin
            rnd = SUM_W'(1) <<< (shift_i - SHIFT_W'(1));
        end

        sum     = SUM_W'(prod) + rnd;
        shifted = sum >>> shift_i;

        if (relu_en_i && shifted[SUM_W-1]) begin
            shifted = '0;
        end

        if (shifted > SAT_HI) begin
            res_o = SAT_HI[DATA_W-1:0];
        end else if (shifted < SAT_LO) begin
            res_o = SAT_LO[DATA_W-1:0];
        end else begin
            res_o = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/pwconv_seq.sv
// ---------------------------------------------------------------------------
// pwconv_seq
// Pointwise (1x1) convolution engine with int8 rescale. Accepts a tile of
// PIXELS x IN_CH activations with its rescale config, then for each of the
// OUT_CH output channels takes one weight vector + bias, runs IN_CH MAC
// cycles on all pixel lanes in parallel, rescales and presents one int8
// vector tagged with its channel index.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    pwconv_seq_if.slave: tile, weight and output streams plus busy
// ---------------------------------------------------------------------------
module pwconv_seq
    import pwconv_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int W_W     = 8,
    parameter int BIAS_W  = 16,
    parameter int PIXELS  = 36,
    parameter int IN_CH   = 32,
    parameter int OUT_CH  = 32,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    pwconv_seq_if.slave   bus
);
    localparam int ACC_W = acc_w(DATA_W, W_W, IN_CH);
    localparam int IC_W  = idx_w(IN_CH);
    localparam int OC_W  = idx_w(OUT_CH);

    localparam logic [IC_W-1:0] IC_LAST = IC_W'(IN_CH - 1);
    localparam logic [OC_W-1:0] OC_LAST = OC_W'(OUT_CH - 1);

    state_t                    state_q, state_d;
    logic signed [W_W-1:0]     w_q [IN_CH];
    logic [MULT_W-1:0]         mult_q;
    logic [SHIFT_W-1:0]        shift_q;
    logic                      relu_q;
    logic [IC_W-1:0]           ic_q;
    logic [OC_W-1:0]           oc_q;

    logic tile_acc;
    logic w_acc;
    logic out_fire;
    logic last_oc;

    assign tile_acc = (state_q == IDLE)   && bus.tile_valid_i;
    assign w_acc    = (state_q == WAIT_W) && bus.w_valid_i;
    assign out_fire = (state_q == OUT)    && bus.out_ready_i;
    assign last_oc  = (oc_q == OC_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.tile_valid_i) state_d = WAIT_W;
            WAIT_W:  if (bus.w_valid_i)    state_d = MAC;
            MAC:     if (ic_q == IC_LAST)  state_d = RSC;
            RSC:     state_d = OUT;
            OUT:     if (bus.out_ready_i)  state_d = last_oc ? IDLE : WAIT_W;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.tile_ready_o = (state_q == IDLE);
        bus.w_ready_o    = (state_q == WAIT_W);
        bus.out_valid_o  = (state_q == OUT);
        bus.out_last_o   = (state_q == OUT) && last_oc;
        bus.out_ch_o     = oc_q;
        bus.busy_o       = (state_q != IDLE);
    end

    // ---------------- Shared registers: weights, cfg, counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < IN_CH; c++) begin
                w_q[c] <= '0;
            end
            mult_q  <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            ic_q    <= '0;
            oc_q    <= '0;
        end else begin
            if (tile_acc) begin
                mult_q  <= bus.scale_mult_i;
                shift_q <= bus.scale_shift_i;
                relu_q  <= bus.relu_en_i;
                oc_q    <= '0;
            end else if (out_fire && !last_oc) begin
                oc_q <= oc_q + OC_W'(1);
            end

            if (w_acc) begin
                for (int c = 0; c < IN_CH; c++) begin
                    w_q[c] <= bus.w_i[c*W_W +: W_W];
                end
                ic_q <= '0;
            end else if (state_q == MAC) begin
                ic_q <= ic_q + IC_W'(1);
            end
        end
    end

    // ---------------- Per-pixel lanes ----------------
    for (genvar gi = 0; gi < PIXELS; gi++) begin : g_lane
        logic signed [DATA_W-1:0]     x_q [IN_CH];
        logic signed [ACC_W-1:0]      acc_q;
        logic [DATA_W-1:0]            res_q;
        logic [DATA_W-1:0]            res_w;
        logic signed [DATA_W+W_W-1:0] prod_w;

        assign prod_w = x_q[ic_q] * w_q[ic_q];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int c = 0; c < IN_CH; c++) begin
                    x_q[c] <= '0;
                end
                acc_q <= '0;
                res_q <= '0;
            end else begin
                if (tile_acc) begin
                    for (int c = 0; c < IN_CH; c++) begin
                        x_q[c] <= bus.tile_pixel_i[(gi*IN_CH + c)*DATA_W +: DATA_W];
                    end
                end

                // Accumulator starts from the sign-extended bias.
                if (w_acc) begin
                    acc_q <= ACC_W'($signed(bus.bias_i));
                end else if (state_q == MAC) begin
                    acc_q <= acc_q + ACC_W'(prod_w);
                end

                if (state_q == RSC) begin
                    res_q <= res_w;
                end
            end
        end

        pwconv_rescale_lane #(
            .ACC_W   (ACC_W),
            .DATA_W  (DATA_W),
            .MULT_W  (MULT_W),
            .SHIFT_W (SHIFT_W)
        ) u_rescale (
            .acc_i     (acc_q),
            .mult_i    (mult_q),
            .shift_i   (shift_q),
            .relu_en_i (relu_q),
            .res_o     (res_w)
        );

        assign bus.out_pixel_o[gi*DATA_W +: DATA_W] = res_q;
    end

endmodule
